// File: rtl/pdm_modulator.sv
// PCM to 1-bit PDM transmitter: 2-entry sample buffer, linear interpolation
// across OSR PDM ticks, first-order sigma-delta modulator and PDM clock.
module pdm_modulator #(
    parameter int WIDTH            = 16,
    parameter int PDM_COUNT_PERIOD = 32,
    parameter int OSR              = 256
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic [WIDTH-1:0] sample_in,
    input  logic             sample_valid_in,
    output logic             sample_ready_out,
    output logic             pdm_clk_out,
    output logic             pdm_tick_out,
    output logic             pdm_out,
    output logic             sample_req_out,
    output logic             underrun_out
);

    localparam int LOG2_OSR = $clog2(OSR);
    localparam int CW       = $clog2(PDM_COUNT_PERIOD);
    localparam int AW       = WIDTH + LOG2_OSR + 1;
    localparam int IW       = WIDTH + 2;

    localparam logic signed [IW-1:0] FS_P = {2'b00, 1'b1, {(WIDTH-1){1'b0}}};
    localparam logic signed [IW-1:0] FS_N = -FS_P;

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t                  state;
    logic [CW-1:0]           cnt;
    logic [WIDTH-1:0]        mem [2];
    logic                    wr_ptr;
    logic                    rd_ptr;
    logic [1:0]              count;
    logic signed [WIDTH-1:0] cur;
    logic signed [WIDTH-1:0] nxt;
    logic signed [AW-1:0]    acc;
    logic [LOG2_OSR-1:0]     phase;
    logic signed [IW-1:0]    integ;

    logic                    full;
    logic                    empty;
    logic                    push;
    logic                    pop;
    logic                    boundary;
    logic signed [WIDTH:0]   diff;
    logic signed [AW-1:0]    diff_ext;
    logic signed [WIDTH-1:0] x;
    logic signed [IW-1:0]    fb;
    logic signed [IW-1:0]    integ_n;

    assign full             = (count == 2'd2);
    assign empty            = (count == 2'd0);
    assign sample_ready_out = !full && !rst_in;
    assign push             = sample_valid_in && sample_ready_out;
    assign boundary         = &phase;
    assign pop              = pdm_tick_out && !empty && (state == IDLE || boundary);

    // Slope of the current segment; acc advances by it once per tick
    assign diff     = {nxt[WIDTH-1], nxt} - {cur[WIDTH-1], cur};
    assign diff_ext = {{LOG2_OSR{diff[WIDTH]}}, diff};

    // Floor of acc / OSR, so x never leaves the [cur, nxt] segment
    assign x       = (state == RUN) ? acc[WIDTH+LOG2_OSR-1:LOG2_OSR] : '0;
    assign fb      = pdm_out ? FS_P : FS_N;
    assign integ_n = integ + {{2{x[WIDTH-1]}}, x} - fb;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state          <= IDLE;
            cnt            <= '0;
            pdm_clk_out    <= 1'b0;
            pdm_tick_out   <= 1'b0;
            pdm_out        <= 1'b0;
            sample_req_out <= 1'b0;
            underrun_out   <= 1'b0;
            mem[0]         <= '0;
            mem[1]         <= '0;
            wr_ptr         <= 1'b0;
            rd_ptr         <= 1'b0;
            count          <= '0;
            cur            <= '0;
            nxt            <= '0;
            acc            <= '0;
            phase          <= '0;
            integ          <= '0;
        end else begin
            cnt            <= (cnt == CW'(PDM_COUNT_PERIOD - 1)) ? '0 : cnt + CW'(1);
            pdm_clk_out    <= (cnt < CW'(PDM_COUNT_PERIOD / 2));
            pdm_tick_out   <= (cnt == '0);
            sample_req_out <= 1'b0;
            underrun_out   <= 1'b0;

            if (push) begin
                mem[wr_ptr] <= sample_in;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, push} - {1'b0, pop};

            if (pdm_tick_out) begin
                integ   <= integ_n;
                pdm_out <= ~integ_n[IW-1];
                unique case (state)
                    IDLE: begin
                        if (!empty) begin
                            cur            <= '0;
                            nxt            <= mem[rd_ptr];
                            acc            <= '0;
                            phase          <= '0;
                            sample_req_out <= 1'b1;
                            state          <= RUN;
                        end
                    end
                    RUN: begin
                        if (boundary) begin
                            cur            <= nxt;
                            acc            <= {nxt[WIDTH-1], nxt, {LOG2_OSR{1'b0}}};
                            phase          <= '0;
                            sample_req_out <= 1'b1;
                            if (!empty) begin
                                nxt <= mem[rd_ptr];
                            end else begin
                                underrun_out <= 1'b1;
                            end
                        end else begin
                            acc   <= acc + diff_ext;
                            phase <= phase + LOG2_OSR'(1);
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pdm_modulator.sv
// Randomised bench for pdm_modulator: tick-level reference model of the
// buffer, interpolator and sigma-delta, compared every cycle.
module tb_pdm_modulator;

    localparam int W   = 16;
    localparam int P   = 8;
    localparam int OSR = 64;
    localparam int FS  = 32768;
    localparam int PCM = OSR * P;

    logic         clk   = 1'b0;
    logic         rst   = 1'b1;
    logic [W-1:0] data  = '0;
    logic         valid = 1'b0;
    logic         ready;
    logic         pdm_clk;
    logic         tick;
    logic         pdm;
    logic         req;
    logic         und;

    pdm_modulator #(
        .WIDTH(W),
        .PDM_COUNT_PERIOD(P),
        .OSR(OSR)
    ) dut (
        .clk_in(clk),
        .rst_in(rst),
        .sample_in(data),
        .sample_valid_in(valid),
        .sample_ready_out(ready),
        .pdm_clk_out(pdm_clk),
        .pdm_tick_out(tick),
        .pdm_out(pdm),
        .sample_req_out(req),
        .underrun_out(und)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // reference model state
    int q[$];
    bit m_rst;
    bit run;
    int cur, nxt, phase, integ, n;
    bit m_pdm, m_tick, m_pclk, m_req, m_und, m_push;

    function automatic int fdiv(longint a, int b);
        longint r;
        r = a / b;
        if ((a % b) != 0 && a < 0) r = r - 1;
        return int'(r);
    endfunction

    function automatic void model_reset();
        q.delete();
        run = 0; cur = 0; nxt = 0; phase = 0; integ = 0; n = 0;
        m_pdm = 0; m_tick = 0; m_pclk = 0; m_req = 0; m_und = 0; m_push = 0;
    endfunction

    function automatic void model_edge(bit v, int d);
        bit rdy;
        int x, in;
        m_push = 0;
        if (m_rst) return;
        rdy = (q.size() < 2);
        m_req = 0;
        m_und = 0;
        if (m_tick) begin
            x = run ? fdiv(longint'(cur) * OSR + longint'(phase) * (nxt - cur), OSR) : 0;
            in = integ + x - (m_pdm ? FS : -FS);
            integ = in;
            m_pdm = (in >= 0);
            if (!run) begin
                if (q.size() > 0) begin
                    nxt = q.pop_front(); cur = 0; phase = 0; run = 1; m_req = 1;
                end
            end else if (phase == OSR - 1) begin
                cur = nxt; phase = 0; m_req = 1;
                if (q.size() > 0) nxt = q.pop_front();
                else m_und = 1;
            end else begin
                phase++;
            end
        end
        if (v && rdy) begin
            q.push_back(d);
            m_push = 1;
        end
        n++;
        m_tick = ((n - 1) % P == 0);
        m_pclk = ((n - 1) % P < P / 2);
    endfunction

    function automatic logic [5:0] obs_vec();
        return {pdm_clk, tick, pdm, ready, req, und};
    endfunction

    function automatic logic [5:0] exp_vec();
        return {m_pclk, m_tick, m_pdm, (!m_rst && q.size() < 2), m_req, m_und};
    endfunction

    task automatic step(input bit v, input logic [W-1:0] d);
        valid = v;
        data  = d;
        @(posedge clk);
        model_edge(v, int'($signed(d)));
        @(negedge clk);
    endtask

    task automatic apply_reset();
        valid = 0;
        rst = 1;
        m_rst = 1;
        model_reset();
        repeat (3) @(negedge clk);
        rst = 0;
        m_rst = 0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        #2;
        rst = 1; m_rst = 1; model_reset();
        #1;
        total++;
        if (obs_vec() !== exp_vec()) begin
            bad++;
            $display("FAIL reset_async got=%b want=%b", obs_vec(), exp_vec());
        end
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            step(1, 16'h1234);
            total++;
            if (obs_vec() !== exp_vec()) begin
                bad++;
                $display("FAIL reset_hold got=%b want=%b", obs_vec(), exp_vec());
            end
        end
        rst = 0; m_rst = 0;
        #1;
        total++;
        if (ready !== 1'b1) begin
            bad++;
            $display("FAIL release_ready got=%b want=1", ready);
        end
    endtask

    task automatic test_idle(input string name);
        int ones = 0, ticks = 0, highs = 0;
        for (int i = 0; i < 256 * P; i++) begin
            step(0, '0);
            total++;
            if (obs_vec() !== exp_vec()) begin
                bad++;
                $display("FAIL %s n=%0d got=%b want=%b", name, n, obs_vec(), exp_vec());
            end
            if (m_tick) ones += int'(pdm);
            ticks += int'(tick);
            highs += int'(pdm_clk);
        end
        total++;
        if (ones < 127 || ones > 129) begin
            bad++;
            $display("FAIL %s_density ones=%0d want=128+/-1", name, ones);
        end
        total++;
        if (ticks != 256 || highs != 128 * P) begin
            bad++;
            $display("FAIL %s_clock ticks=%0d highs=%0d want=256,%0d", name, ticks, highs, 128 * P);
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] s [3];
        int k = 0, budget = 4 * PCM;
        apply_reset();
        for (int i = 0; i < 3; i++) s[i] = W'($urandom);
        repeat ($urandom_range(3, 20)) step(0, '0);
        while (k < 3 && budget > 0) begin
            step(1, s[k]);
            budget--;
            total++;
            if (obs_vec() !== exp_vec()) begin
                bad++;
                $display("FAIL b2b_fill n=%0d got=%b want=%b", n, obs_vec(), exp_vec());
            end
            if (m_push) k++;
        end
        total++;
        if (k != 3) begin
            bad++;
            $display("FAIL b2b_timeout accepted=%0d want=3", k);
        end
        for (int i = 0; i < 3 * PCM; i++) begin
            step(0, '0);
            total++;
            if (obs_vec() !== exp_vec()) begin
                bad++;
                $display("FAIL b2b_drain n=%0d got=%b want=%b", n, obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_constant(input logic [W-1:0] v, input int lo, input int hi,
                                 input string name);
        int ones = 0, ticks = 0, budget = 8 * PCM;
        apply_reset();
        while (ticks < 2 * OSR + 2 + 256 && budget > 0) begin
            step(1, v);
            budget--;
            total++;
            if (obs_vec() !== exp_vec()) begin
                bad++;
                $display("FAIL %s n=%0d got=%b want=%b", name, n, obs_vec(), exp_vec());
            end
            if (m_tick) begin
                ticks++;
                if (ticks > 2 * OSR + 2) ones += int'(pdm);
            end
        end
        total++;
        if (ones < lo || ones > hi) begin
            bad++;
            $display("FAIL %s_density ones=%0d want=%0d..%0d", name, ones, lo, hi);
        end
    endtask

    task automatic test_ramp();
        int k = 0, c = 0, nreq = 0, last = -1;
        apply_reset();
        for (int i = 0; i < 3 * PCM + 2 * P; i++) begin
            step(1, (k == 0) ? 16'd0 : 16'd1024);
            c++;
            total++;
            if (obs_vec() !== exp_vec()) begin
                bad++;
                $display("FAIL ramp n=%0d got=%b want=%b", n, obs_vec(), exp_vec());
            end
            if (m_push) k++;
            if (req === 1'b1) begin
                if (last >= 0) begin
                    total++;
                    if (c - last != PCM) begin
                        bad++;
                        $display("FAIL ramp_req_gap got=%0d want=%0d", c - last, PCM);
                    end
                end
                last = c;
                nreq++;
            end
        end
        total++;
        if (nreq < 3) begin
            bad++;
            $display("FAIL ramp_req_count got=%0d want>=3", nreq);
        end
    endtask

    task automatic test_underrun();
        int k = 0, c = 0, nund = 0, last = -1, budget = 8 * PCM;
        apply_reset();
        while (k < 2 && budget > 0) begin
            step(1, W'($urandom));
            budget--;
            if (m_push) k++;
        end
        while (nund < 3 && budget > 0) begin
            step(0, '0);
            budget--;
            c++;
            total++;
            if (obs_vec() !== exp_vec()) begin
                bad++;
                $display("FAIL underrun n=%0d got=%b want=%b", n, obs_vec(), exp_vec());
            end
            if (und === 1'b1) begin
                if (last >= 0) begin
                    total++;
                    if (c - last != PCM) begin
                        bad++;
                        $display("FAIL underrun_gap got=%0d want=%0d", c - last, PCM);
                    end
                end
                last = c;
                nund++;
            end
        end
        total++;
        if (nund != 3) begin
            bad++;
            $display("FAIL underrun_timeout pulses=%0d want=3", nund);
        end
        nund = 0;
        for (int i = 0; i < 2 * PCM; i++) begin
            step(1, W'($urandom));
            total++;
            if (obs_vec() !== exp_vec()) begin
                bad++;
                $display("FAIL resume n=%0d got=%b want=%b", n, obs_vec(), exp_vec());
            end
            nund += int'(und);
        end
        total++;
        if (nund != 0) begin
            bad++;
            $display("FAIL resume_underrun pulses=%0d want=0", nund);
        end
    endtask

    task automatic test_random();
        apply_reset();
        for (int i = 0; i < 6 * PCM; i++) begin
            step(($urandom % 4) == 0, W'($urandom));
            total++;
            if (obs_vec() !== exp_vec()) begin
                bad++;
                $display("FAIL random n=%0d got=%b want=%b", n, obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_reset_mid();
        int budget = 4 * PCM;
        apply_reset();
        while (!(run && q.size() == 2) && budget > 0) begin
            step(1, W'($urandom));
            budget--;
        end
        repeat ($urandom_range(1, 40)) step(0, '0);
        total++;
        if (!(run && q.size() == 2)) begin
            bad++;
            $display("FAIL midrst_setup fifo=%0d run=%0d want=2,1", q.size(), run);
        end
        #2;
        rst = 1; m_rst = 1; model_reset();
        #1;
        total++;
        if (obs_vec() !== exp_vec()) begin
            bad++;
            $display("FAIL midrst_async got=%b want=%b", obs_vec(), exp_vec());
        end
        @(negedge clk);
        step(1, 16'h7FFF);
        total++;
        if (obs_vec() !== exp_vec()) begin
            bad++;
            $display("FAIL midrst_hold got=%b want=%b", obs_vec(), exp_vec());
        end
        rst = 0; m_rst = 0;
        test_idle("midrst_idle");
    endtask

    initial begin
        model_reset();
        m_rst = 1;
        test_reset();
        test_idle("idle");
        test_back_to_back();
        test_constant(16'h7FFF, 255, 256, "const_max");
        test_constant(16'h8000, 0, 0, "const_min");
        test_constant(16'h4000, 191, 193, "const_half");
        test_ramp();
        test_underrun();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
